// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS program-counter sequencer.
package mips_pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_RET,
    SEL_ERET,
    SEL_EXC,
    SEL_HOLD
  } next_pc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

  // Pointer width for a return stack of the given depth (at least one bit).
  function automatic int RAS_PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mips_return_stack.sv
// Circular return-address stack with a top pointer and saturating count.
// When full, a push overwrites the oldest entry. Pop on an empty stack is a no-op.
// Pop and push in the same cycle replace the top entry (count unchanged),
// or behave as a plain push when the stack is empty.
module mips_return_stack
  import mips_pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [RAS_PTR_W(DEPTH):0]  count
);

  localparam int PW = RAS_PTR_W(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [PW:0]      cnt_nxt;
  logic [PW-1:0]    wr_idx;
  logic             wr_en;

  assign top = mem[ptr];

  // Next pointer/count: pop first, then push on top of the popped state.
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = count;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    if (pop && (count != '0)) begin
      ptr_nxt = ptr - 1'b1;
      cnt_nxt = count - 1'b1;
    end
    if (push) begin
      wr_en   = 1'b1;
      wr_idx  = ptr_nxt + 1'b1;
      ptr_nxt = ptr_nxt + 1'b1;
      if (cnt_nxt != FULL) cnt_nxt = cnt_nxt + 1'b1;
    end
  end

  // Stack storage, pointer and count registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= push_data;
      ptr   <= ptr_nxt;
      count <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mips_pc_sequencer.sv
// Program-counter unit: fixed-priority next-PC selection, alignment trap,
// PC and EPC registers, and a return-address stack for call/return.
module mips_pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int                    INSTR_BYTES  = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [ADDR_WIDTH-1:0]        branch_target,
  input  logic                         jump,
  input  logic [ADDR_WIDTH-1:0]        jump_target,
  input  logic                         call,
  input  logic                         ret,
  input  logic [ADDR_WIDTH-1:0]        jr_target,
  input  logic                         exception,
  input  logic                         eret,
  output logic [ADDR_WIDTH-1:0]        current_ins_addr,
  output logic [ADDR_WIDTH-1:0]        pc_plus,
  output logic [ADDR_WIDTH-1:0]        epc,
  output logic                         misaligned,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] epc_q;
  logic                  mis_q;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] target;
  logic                  check_align;
  logic                  mis_now;
  logic                  ras_push;
  logic                  ras_pop;
  next_pc_sel_e          sel;

  assign current_ins_addr = pc_q;
  assign pc_plus          = pc_q + ADDR_WIDTH'(INSTR_BYTES);
  assign epc              = epc_q;
  assign misaligned       = mis_q;

  // Fixed-priority source selection; exception is the only thing that beats stall.
  always_comb begin
    if (exception)         sel = SEL_EXC;
    else if (stall)        sel = SEL_HOLD;
    else if (eret)         sel = SEL_ERET;
    else if (ret)          sel = SEL_RET;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
    else                   sel = SEL_SEQ;
  end

  // Target mux; only redirected targets are subject to the alignment check.
  always_comb begin
    target      = pc_plus;
    check_align = 1'b0;
    case (sel)
      SEL_BRANCH: begin target = branch_target; check_align = 1'b1; end
      SEL_JUMP:   begin target = jump_target;   check_align = 1'b1; end
      SEL_RET: begin
        target      = (ras_count != '0) ? ras_top : jr_target;
        check_align = 1'b1;
      end
      SEL_ERET:   begin target = epc_q;         check_align = 1'b1; end
      default:    begin target = pc_plus;       check_align = 1'b0; end
    endcase
  end

  assign mis_now  = check_align && ((target & ALIGN_MASK) != '0);
  // A link is pushed for JAL, and for JALR (ret with jump+call); the pop happens first.
  assign ras_push = call && jump && ((sel == SEL_RET) || (sel == SEL_JUMP));
  assign ras_pop  = (sel == SEL_RET);

  mips_return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .count     (ras_count)
  );

  // PC, EPC and misalignment-pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      case (sel)
        SEL_EXC: begin
          pc_q  <= EXC_VECTOR;
          epc_q <= pc_q;
          mis_q <= 1'b0;
        end
        SEL_HOLD: begin
          mis_q <= 1'b0;
        end
        default: begin
          if (mis_now) begin
            pc_q  <= EXC_VECTOR;
            epc_q <= pc_q;
            mis_q <= 1'b1;
          end else begin
            pc_q  <= target;
            mis_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Scoreboard bench for mips_pc_sequencer: a queue-based reference model predicts
// each cycle's registered outputs; a monitor pops and compares after each edge.
module tb_mips_pc_sequencer;

  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam int          DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 0, branch_taken = 0, jump = 0, call = 0, ret = 0, exception = 0, eret = 0;
  logic [31:0] branch_target = 0, jump_target = 0, jr_target = 0;
  logic [31:0] pc, pc_plus, epc;
  logic        misaligned;
  logic [2:0]  ras_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_pc_sequencer #(
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EXC),
    .INSTR_BYTES  (4),
    .RAS_DEPTH    (DEP)
  ) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .call             (call),
    .ret              (ret),
    .jr_target        (jr_target),
    .exception        (exception),
    .eret             (eret),
    .current_ins_addr (pc),
    .pc_plus          (pc_plus),
    .epc              (epc),
    .misaligned       (misaligned),
    .ras_count        (ras_count)
  );

  typedef struct {
    logic stall, br, jump, call, ret, exc, eret;
    logic [31:0] bt, jt, jr;
  } stim_t;

  typedef struct {
    logic [31:0] pc, epc;
    logic        mis;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.stall = 0; s.br = 0; s.jump = 0; s.call = 0; s.ret = 0; s.exc = 0; s.eret = 0;
    s.bt = 0; s.jt = 0; s.jr = 0;
    return s;
  endfunction

  function automatic void model_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEP) m_ras.delete(0);
  endfunction

  function automatic void model_reset();
    m_pc  = RV;
    m_epc = 0;
    m_ras.delete();
  endfunction

  // Reference behaviour: one instruction's worth of next-PC rules.
  function automatic void model_step(input stim_t s);
    logic [31:0] tgt, old_pc;
    logic        chk, mis;
    old_pc = m_pc;
    mis    = 0;
    tgt    = old_pc + 4;
    chk    = 0;
    if (s.exc) begin
      m_epc = old_pc;
      m_pc  = EXC;
    end else if (!s.stall) begin
      chk = 1;
      if (s.eret) tgt = m_epc;
      else if (s.ret) begin
        if (m_ras.size() > 0) tgt = m_ras.pop_back();
        else tgt = s.jr;
        if (s.call && s.jump) model_push(old_pc + 4);
      end else if (s.jump) begin
        tgt = s.jt;
        if (s.call) model_push(old_pc + 4);
      end else if (s.br) tgt = s.bt;
      else chk = 0;
      if (chk && (tgt[1:0] != 2'b00)) begin
        m_epc = old_pc;
        m_pc  = EXC;
        mis   = 1;
      end else begin
        m_pc = tgt;
      end
    end
    exp_q.push_back('{pc: m_pc, epc: m_epc, mis: mis, cnt: m_ras.size()});
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    stall = s.stall; branch_taken = s.br; branch_target = s.bt;
    jump = s.jump; jump_target = s.jt; call = s.call;
    ret = s.ret; jr_target = s.jr; exception = s.exc; eret = s.eret;
    model_step(s);
  endtask

  task automatic step(input stim_t s);
    apply(s);
    @(posedge clk);
    #2;
  endtask

  task automatic do_idle();
    step(idle());
  endtask

  task automatic do_jump(input logic [31:0] t, input logic c);
    stim_t s = idle();
    s.jump = 1; s.jt = t; s.call = c;
    step(s);
  endtask

  task automatic do_ret(input logic [31:0] jr);
    stim_t s = idle();
    s.ret = 1; s.jr = jr;
    step(s);
  endtask

  // Monitor: every clock with reset released produces one predicted state.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pc", pc, e.pc);
      check("sb_epc", epc, e.epc);
      check("sb_misaligned", 32'(misaligned), 32'(e.mis));
      check("sb_ras_count", 32'(ras_count), 32'(e.cnt));
      check("sb_pc_plus", pc_plus, e.pc + 32'd4);
    end
  end

  initial begin
    stim_t s;
    model_reset();
    #12;
    check("rst_pc", pc, RV);
    check("rst_epc", epc, 0);
    check("rst_mis", 32'(misaligned), 0);
    check("rst_ras_count", 32'(ras_count), 0);
    check("rst_pc_plus", pc_plus, 32'd4);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Free-running sequential fetch.
    do_idle(); check("seq_pc1", pc, 32'h4);
    do_idle(); check("seq_pc2", pc, 32'h8);
    do_idle(); check("seq_pc3", pc, 32'hC);
    do_idle(); check("seq_pc4", pc, 32'h10);

    // Call then return.
    do_jump(32'h100, 1); check("call_pc", pc, 32'h100); check("call_cnt", 32'(ras_count), 1);
    do_ret(32'hDEAD_0000); check("ret_pc", pc, 32'h14); check("ret_cnt", 32'(ras_count), 0);

    // Nested calls beyond RAS depth.
    do_jump(32'h0, 0);
    for (int i = 1; i <= 5; i++) do_jump(32'(i) << 8, 1);
    check("nest_pc", pc, 32'h500);
    check("nest_cnt_sat", 32'(ras_count), 4);
    do_ret(32'h1230); check("nret1", pc, 32'h404);
    do_ret(32'h1230); check("nret2", pc, 32'h304);
    do_ret(32'h1230); check("nret3", pc, 32'h204);
    do_ret(32'h1230); check("nret4", pc, 32'h104);
    do_ret(32'h1230); check("nret_empty", pc, 32'h1230);
    check("nret_cnt", 32'(ras_count), 0);

    // Exception overrides stall; eret returns.
    do_jump(32'h40, 0);
    s = idle(); s.stall = 1; s.jump = 1; s.jt = 32'h60; s.exc = 1;
    step(s);
    check("exc_pc", pc, EXC); check("exc_epc", epc, 32'h40);
    s = idle(); s.eret = 1;
    step(s);
    check("eret_pc", pc, 32'h40);

    // Misaligned branch trap.
    do_jump(32'h20, 0);
    s = idle(); s.br = 1; s.bt = 32'h102;
    step(s);
    check("mis_pc", pc, EXC); check("mis_pulse", 32'(misaligned), 1); check("mis_epc", epc, 32'h20);
    do_idle(); check("mis_clear", 32'(misaligned), 0);

    // JALR: pop then push, count unchanged.
    do_jump(32'h600, 0);
    do_jump(32'h700, 1);
    s = idle(); s.ret = 1; s.jump = 1; s.call = 1; s.jt = 32'h900; s.jr = 32'h0;
    step(s);
    check("jalr_pc", pc, 32'h604); check("jalr_cnt", 32'(ras_count), 1);
    do_ret(32'h0); check("jalr_ret", pc, 32'h704);

    // Stall holds PC against a jump.
    s = idle(); s.stall = 1; s.jump = 1; s.call = 1; s.jt = 32'h800;
    step(s);
    check("stall_pc", pc, 32'h704); check("stall_cnt", 32'(ras_count), 0);

    // Wrap-around of sequential increment.
    do_jump(32'hFFFF_FFFC, 0);
    do_idle(); check("wrap_pc", pc, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.stall = ($urandom_range(0, 9) == 0);
      s.exc   = ($urandom_range(0, 24) == 0);
      s.eret  = ($urandom_range(0, 19) == 0);
      s.ret   = ($urandom_range(0, 5) == 0);
      s.jump  = ($urandom_range(0, 3) == 0);
      s.call  = s.jump && ($urandom_range(0, 1) == 1);
      s.br    = ($urandom_range(0, 4) == 0);
      s.bt    = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      s.jt    = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      s.jr    = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      apply(s);
    end
    @(posedge clk);
    #2;

    // Asynchronous reset in the middle of a stalled call cycle.
    do_jump(32'h900, 1);
    s = idle(); s.exc = 1;
    step(s);
    s = idle(); s.stall = 1; s.jump = 1; s.call = 1; s.jt = 32'hA00;
    apply(s);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("arst_pc", pc, RV);
    check("arst_epc", epc, 0);
    check("arst_cnt", 32'(ras_count), 0);
    check("arst_mis", 32'(misaligned), 0);
    @(posedge clk);
    #2;
    check("arst_hold_pc", pc, RV);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
